uart_rx_zhiwen: RTL
===================

UART_RX_ZHIWEN -- requirements
Module: uart_rx_zhiwen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 57600, line rate; BAUD_DIV = CLK_FREQ/BAUD, integer-truncated (868 at defaults).
REQ-003 SHALL have parameter MOD_ADDR, default 32'hFFFFFFFF, expected fingerprint-module address.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 200000, maximum idle gap between bytes inside a packet, in clk cycles.
REQ-005 SHALL have parameter MAX_LEN, default 16'd256, largest accepted packet length field.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port TX232, input, 1, serial line driven by the fingerprint module; idle high.
REQ-009 SHALL have port rx_byte, output, 8, last received data byte.
REQ-010 SHALL have port rx_byte_vld, output, 1, one-cycle pulse when rx_byte is updated.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit samples 0.
REQ-012 SHALL have port ack_pid, output, 8, PID of the last good packet.
REQ-013 SHALL have port ack_code, output, 8, first payload byte (confirmation code) of the last good packet.
REQ-014 SHALL have port ack_len, output, 16, length field of the last good packet.
REQ-015 SHALL have port pkt_done, output, 1, one-cycle pulse on acceptance of a good packet.
REQ-016 SHALL have port pkt_err, output, 1, one-cycle pulse on packet abort.
REQ-017 SHALL have port busy, output, 1, high while the byte receiver or parser is not idle.

Function
REQ-018 SHALL pass TX232 through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-019 Byte FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge.
REQ-020 START SHALL resample at BAUD_DIV/2 cycles; line high -> glitch, return to IDLE, no output.
REQ-021 DATA SHALL sample 8 bits LSB first, one every BAUD_DIV cycles from the start mid-point.
REQ-022 STOP SHALL sample after a further BAUD_DIV cycles; 1 -> rx_byte_vld one cycle later; 0 -> frame_err instead, byte discarded; both cases return to IDLE.
REQ-023 Parser states HDR0, HDR1, ADDR(4 bytes, MSB first), PID, LENH, LENL, BODY, SUMH, SUML; advances only on rx_byte_vld.
REQ-024 HDR0 SHALL discard bytes other than 8'hEF; HDR1 on 8'h01 -> ADDR, on 8'hEF stays HDR1, otherwise -> HDR0 silently.
REQ-025 ADDR mismatch against MOD_ADDR SHALL pulse pkt_err after the 4th address byte and return to HDR0.
REQ-026 Length field L SHALL satisfy 3 <= L <= MAX_LEN; else pkt_err after LENL, return to HDR0.
REQ-027 BODY SHALL consume L-2 bytes; the first is captured as candidate confirmation code.
REQ-028 Checksum = 16-bit wrap-around sum of PID, LENH, LENL and all BODY bytes, compared with {SUMH,SUML}.
REQ-029 On SUML: match -> ack_pid/ack_code/ack_len update and pkt_done pulses the cycle after rx_byte_vld; mismatch -> pkt_err, ack_* unchanged.
REQ-030 ack_* SHALL hold value until the next pkt_done.
REQ-031 frame_err while parser not in HDR0 SHALL abort: pkt_err same cycle, parser -> HDR0.
REQ-032 Parser outside HDR0 with no rx_byte_vld for TIMEOUT_CYC cycles SHALL pulse pkt_err and return to HDR0; counter clears on each rx_byte_vld.
REQ-033 pkt_done and pkt_err SHALL never assert in the same cycle.

Reset
REQ-034 rst_n low SHALL asynchronously force byte FSM IDLE, parser HDR0, all counters 0, all outputs 0 (ack_* = 0).
REQ-035 Reset mid-byte or mid-packet SHALL discard partial data; first byte after release requires a new falling edge.

Configuration
REQ-036 Macro ZHIWEN_CHKSUM_EN defined: checksum compared per REQ-028/029.
REQ-037 Macro ZHIWEN_CHKSUM_EN undefined: SUMH/SUML consumed but not compared, no checksum adder; packet reaching SUML always yields pkt_done.

Verification
REQ-038 Bytes EF 01 FF FF FF FF 07 00 03 00 00 0A at 57600 -> 12 rx_byte_vld, pkt_done once, ack_pid=07, ack_code=00, ack_len=0003.
REQ-039 Same packet, last byte 0B, ZHIWEN_CHKSUM_EN defined -> pkt_err once, no pkt_done, ack_* keep prior values.
REQ-040 TX232 low for 100 cycles then high -> no rx_byte_vld, no frame_err, busy back to 0.
REQ-041 Byte 55 with stop bit 0 after EF 01 -> frame_err and pkt_err same cycle, parser HDR0.
REQ-042 EF 01 FF FF then line idle TIMEOUT_CYC cycles -> exactly one pkt_err; following good packet -> pkt_done.
REQ-043 rst_n low during 5th data bit -> all outputs 0 immediately; next full packet after release decodes correctly.

Source files
------------

// File: rtl/uart_rx_zhiwen.sv
// UART receiver with ack-packet parser for a ZhiWen fingerprint module.
// Optional macro ZHIWEN_CHKSUM_EN enables checksum comparison on SUMH/SUML.
module uart_rx_zhiwen #(
  parameter int          CLK_FREQ    = 50000000,
  parameter int          BAUD        = 57600,
  parameter logic [31:0] MOD_ADDR    = 32'hFFFFFFFF,
  parameter int          TIMEOUT_CYC = 200000,
  parameter logic [15:0] MAX_LEN     = 16'd256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        TX232,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_vld,
  output logic        frame_err,
  output logic [7:0]  ack_pid,
  output logic [7:0]  ack_code,
  output logic [15:0] ack_len,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic        busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic [3:0] {
    P_HDR0, P_HDR1, P_ADDR, P_PID, P_LENH, P_LENL, P_BODY, P_SUMH, P_SUML
  } pkt_state_t;

  // Synchronizer flops reset low so a line already low at release gives no edge.
  logic sync1, sync2, sync_prev;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= TX232;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fall = sync_prev & ~sync2;

  byte_state_t     bstate, bnext;
  logic [CW-1:0]   bcnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            tick, bit_sample, stop_good, stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bstate <= B_IDLE;
    else        bstate <= bnext;
  end

  always_comb begin
    bnext = bstate;
    case (bstate)
      B_IDLE:  if (fall) bnext = B_START;
      B_START: if (tick) bnext = sync2 ? B_IDLE : B_DATA;
      B_DATA:  if (tick && bit_idx == 3'd7) bnext = B_STOP;
      B_STOP:  if (tick) bnext = B_IDLE;
      default: bnext = B_IDLE;
    endcase
  end

  always_comb begin
    tick       = 1'b0;
    bit_sample = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (bstate)
      B_START: tick = (bcnt == HALF_LAST);
      B_DATA: begin
        tick       = (bcnt == DIV_LAST);
        bit_sample = (bcnt == DIV_LAST);
      end
      B_STOP: begin
        tick      = (bcnt == DIV_LAST);
        stop_good = (bcnt == DIV_LAST) && sync2;
        stop_bad  = (bcnt == DIV_LAST) && !sync2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt        <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      rx_byte     <= 8'h00;
      rx_byte_vld <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_byte_vld <= stop_good;
      frame_err   <= stop_bad;
      if (bstate == B_IDLE || tick) bcnt <= '0;
      else                          bcnt <= bcnt + 1'b1;
      if (bstate != B_DATA) bit_idx <= 3'd0;
      else if (bit_sample)  bit_idx <= bit_idx + 3'd1;
      if (bit_sample) shift <= {sync2, shift[7:1]};
      if (stop_good)  rx_byte <= shift;
    end
  end

  pkt_state_t     pstate, pnext;
  logic [1:0]     addr_idx;
  logic           addr_bad;
  logic [7:0]     addr_exp;
  logic [7:0]     pid_r, code_r, len_hi;
  logic [15:0]    len_r, len_val, body_cnt;
  logic           first_body;
  logic [TW-1:0]  to_cnt;
  logic           frame_abort, to_fire, addr_fail, len_fail, sum_fail, sum_ok;
  logic           done_set, err_set;

  assign len_val = {len_hi, rx_byte};

`ifdef ZHIWEN_CHKSUM_EN
  logic [15:0] sum;
  logic [7:0]  sum_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum    <= 16'h0000;
      sum_hi <= 8'h00;
    end else if (rx_byte_vld) begin
      case (pstate)
        P_PID:                  sum    <= {8'h00, rx_byte};
        P_LENH, P_LENL, P_BODY: sum    <= sum + {8'h00, rx_byte};
        P_SUMH:                 sum_hi <= rx_byte;
        default: ;
      endcase
    end
  end

  assign sum_ok = (sum == {sum_hi, rx_byte});
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pstate <= P_HDR0;
    else        pstate <= pnext;
  end

  always_comb begin
    pnext = pstate;
    if (frame_abort || to_fire) begin
      pnext = P_HDR0;
    end else if (rx_byte_vld) begin
      case (pstate)
        P_HDR0: if (rx_byte == 8'hEF) pnext = P_HDR1;
        P_HDR1: begin
          if (rx_byte == 8'h01)      pnext = P_ADDR;
          else if (rx_byte != 8'hEF) pnext = P_HDR0;
        end
        P_ADDR: if (addr_idx == 2'd3) pnext = addr_fail ? P_HDR0 : P_PID;
        P_PID:  pnext = P_LENH;
        P_LENH: pnext = P_LENL;
        P_LENL: pnext = len_fail ? P_HDR0 : P_BODY;
        P_BODY: if (body_cnt == 16'd1) pnext = P_SUMH;
        P_SUMH: pnext = P_SUML;
        P_SUML: pnext = P_HDR0;
        default: pnext = P_HDR0;
      endcase
    end
  end

  // Abort sources are exclusive with the SUML byte, so done/err never coincide.
  always_comb begin
    case (addr_idx)
      2'd0:    addr_exp = MOD_ADDR[31:24];
      2'd1:    addr_exp = MOD_ADDR[23:16];
      2'd2:    addr_exp = MOD_ADDR[15:8];
      default: addr_exp = MOD_ADDR[7:0];
    endcase
    frame_abort = stop_bad && (pstate != P_HDR0);
    to_fire     = (pstate != P_HDR0) && !rx_byte_vld && (to_cnt == TO_LAST);
    addr_fail   = rx_byte_vld && (pstate == P_ADDR) && (addr_idx == 2'd3) &&
                  (addr_bad || (rx_byte != addr_exp));
    len_fail    = rx_byte_vld && (pstate == P_LENL) &&
                  ((len_val < 16'd3) || (len_val > MAX_LEN));
    sum_fail    = rx_byte_vld && (pstate == P_SUML) && !sum_ok;
    done_set    = rx_byte_vld && (pstate == P_SUML) && sum_ok && !frame_abort && !to_fire;
    err_set     = frame_abort || to_fire || addr_fail || len_fail || sum_fail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_idx   <= 2'd0;
      addr_bad   <= 1'b0;
      pid_r      <= 8'h00;
      code_r     <= 8'h00;
      len_hi     <= 8'h00;
      len_r      <= 16'h0000;
      body_cnt   <= 16'h0000;
      first_body <= 1'b0;
      to_cnt     <= '0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      ack_pid    <= 8'h00;
      ack_code   <= 8'h00;
      ack_len    <= 16'h0000;
    end else begin
      pkt_done <= done_set;
      pkt_err  <= err_set;
      if (pstate == P_HDR0 || rx_byte_vld || to_fire) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + 1'b1;
      if (pstate != P_ADDR) begin
        addr_idx <= 2'd0;
        addr_bad <= 1'b0;
      end else if (rx_byte_vld) begin
        addr_idx <= addr_idx + 2'd1;
        addr_bad <= addr_bad | (rx_byte != addr_exp);
      end
      if (rx_byte_vld) begin
        case (pstate)
          P_PID:  pid_r  <= rx_byte;
          P_LENH: len_hi <= rx_byte;
          P_LENL: begin
            len_r      <= len_val;
            body_cnt   <= len_val - 16'd2;
            first_body <= 1'b1;
          end
          P_BODY: begin
            if (first_body) code_r <= rx_byte;
            first_body <= 1'b0;
            body_cnt   <= body_cnt - 16'd1;
          end
          default: ;
        endcase
      end
      if (done_set) begin
        ack_pid  <= pid_r;
        ack_code <= code_r;
        ack_len  <= len_r;
      end
    end
  end

  assign busy = (bstate != B_IDLE) || (pstate != P_HDR0);

endmodule
